// File: rtl/seq_cpu_core_pkg.sv
// seq_cpu_core_pkg: opcodes, FSM state encoding and instruction field positions shared by the core
package seq_cpu_core_pkg;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
endpackage

// File: rtl/seq_cpu_core_alu.sv
// cpu_alu: combinational ALU for the sequential core
// ports: op (opcode), a/b (operands) -> result, carry_out (carry or borrow), flag_update (op is an ALU op)
module cpu_alu
    import seq_cpu_core_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          carry_out,
    output logic          flag_update
);
    logic [DW:0] sum;
    logic [DW:0] diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    // the extra top bit of the difference is the borrow (a < b unsigned)
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        result      = '0;
        carry_out   = 1'b0;
        flag_update = 1'b1;
        case (op)
            OP_ADD:  {carry_out, result} = sum;
            OP_SUB:  {carry_out, result} = diff;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: flag_update = 1'b0;
        endcase
    end
endmodule

// File: rtl/seq_cpu_core.sv
// seq_cpu_core: multi-cycle 16-bit-instruction CPU (FETCH/DECODE/EXEC/MEM) with 8 registers and private memories
// ports: clk, reset (async, active-high), start (run from address 0), prog_we/prog_addr/prog_data (imem load,
//        only in IDLE/HALT), dbg_raddr/dbg_rdata (register peek), dm_raddr/dm_rdata (dmem peek),
//        pc, busy, halted, carry, zero
module seq_cpu_core
    import seq_cpu_core_pkg::*;
#(
    parameter int DW    = 8,
    parameter int PC_W  = 8,
    parameter int DM_AW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             prog_we,
    input  logic [PC_W-1:0]  prog_addr,
    input  logic [15:0]      prog_data,
    input  logic [2:0]       dbg_raddr,
    output logic [DW-1:0]    dbg_rdata,
    input  logic [DM_AW-1:0] dm_raddr,
    output logic [DW-1:0]    dm_rdata,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             halted,
    output logic             carry,
    output logic             zero
);
    state_t state, state_nx;
    logic [15:0] imem [2**PC_W];
    logic [DW-1:0] dmem [2**DM_AW];
    logic [DW-1:0] regs [8];
    logic [15:0] ir;
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [DM_AW-1:0] dm_addr;
    logic [DW-1:0] alu_res;
    logic alu_c, alu_fu, take, idle_like;
    assign op        = ir[OP_HI:OP_LO];
    assign rd        = ir[RD_HI:RD_LO];
    assign rs1       = ir[RS1_HI:RS1_LO];
    assign rs2       = ir[RS2_HI:RS2_LO];
    assign imm       = ir[IMM_HI:IMM_LO];
    assign dm_addr   = DM_AW'(imm);
    assign take      = op == OP_JMP || (op == OP_JZ && zero) || (op == OP_JC && carry);
    assign idle_like = state == S_IDLE || state == S_HALT;
    assign busy      = !idle_like;
    assign halted    = state == S_HALT;
    assign dbg_rdata = regs[dbg_raddr];
    assign dm_rdata  = dmem[dm_raddr];

    cpu_alu #(.DW(DW)) u_alu (
        .op          (op),
        .a           (regs[rs1]),
        .b           (regs[rs2]),
        .result      (alu_res),
        .carry_out   (alu_c),
        .flag_update (alu_fu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALT: state_nx = start ? S_FETCH : state;
            S_FETCH:        state_nx = S_DECODE;
            S_DECODE:       state_nx = S_EXEC;
            S_EXEC:         state_nx = (op == OP_LD || op == OP_ST) ? S_MEM : op == OP_HALT ? S_HALT : S_FETCH;
            S_MEM:          state_nx = S_FETCH;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            ir    <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (idle_like && start) pc <= '0;
            if (state == S_FETCH) ir <= imem[pc];
            if (state == S_EXEC) begin
                // pc stays on the HALT word so a halted core reports where it stopped
                if (op != OP_HALT) pc <= take ? PC_W'(imm) : pc + PC_W'(1);
                if (alu_fu) begin
                    regs[rd] <= alu_res;
                    carry    <= alu_c;
                    zero     <= alu_res == '0;
                end
                if (op == OP_LDI) regs[rd] <= DW'(imm);
            end
            if (state == S_MEM && op == OP_LD) regs[rd] <= dmem[dm_addr];
        end
    end

    // memories are not reset; a reset moves state out of MEM before any store can land
    always_ff @(posedge clk) begin
        if (prog_we && idle_like) imem[prog_addr] <= prog_data;
        if (state == S_MEM && op == OP_ST) dmem[dm_addr] <= regs[rd];
    end
endmodule

// File: tb/tb_seq_cpu_core.sv
// tb_seq_cpu_core: directed and random programs checked against an instruction-level interpreter
module tb_seq_cpu_core;
    logic clk = 1'b0;
    logic reset, start, prog_we, w_start, w_we;
    logic [7:0] prog_addr, dm_raddr, dbg_rdata, dm_rdata, pc, w_dbg, w_dm;
    logic [15:0] prog_data;
    logic [2:0] dbg_raddr, w_pc;
    logic busy, halted, carry, zero, w_busy, w_halted, w_carry, w_zero;
    int total = 0;
    int bad = 0;
    logic [15:0] prog [256];
    logic [7:0] mr [8];
    logic [7:0] mdm [256];
    bit mc, mz;
    int mcyc, mpc;

    always #5 clk = ~clk;

    seq_cpu_core u_dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .dm_raddr(dm_raddr),
        .dm_rdata(dm_rdata), .pc(pc), .busy(busy), .halted(halted), .carry(carry), .zero(zero)
    );

    seq_cpu_core #(.PC_W(3)) u_wrap (
        .clk(clk), .reset(reset), .start(w_start), .prog_we(w_we), .prog_addr(prog_addr[2:0]),
        .prog_data(prog_data), .dbg_raddr(dbg_raddr), .dbg_rdata(w_dbg), .dm_raddr(dm_raddr),
        .dm_rdata(w_dm), .pc(w_pc), .busy(w_busy), .halted(w_halted), .carry(w_carry), .zero(w_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ri(input int op, input int rd, input int imm);
        return {op[3:0], rd[2:0], 1'b0, imm[7:0]};
    endfunction

    function automatic logic [15:0] rr(input int op, input int rd, input int a, input int b);
        return {op[3:0], rd[2:0], a[2:0], b[2:0], 3'b000};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 8; i++) mr[i] = 8'h00;
        mc = 1'b0;
        mz = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            prog_we = 1'b1;
            prog_addr = 8'(i);
            prog_data = prog[i];
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic wait_halt(inout int cyc);
        while (!halted && cyc < 3000) begin
            step();
            cyc++;
        end
    endtask

    task automatic run(output int cyc);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        wait_halt(cyc);
    endtask

    task automatic rd_reg(input int i, output logic [7:0] v);
        dbg_raddr = 3'(i);
        #1;
        v = dbg_rdata;
    endtask

    task automatic rd_dm(input int a, output logic [7:0] v);
        dm_raddr = 8'(a);
        #1;
        v = dm_rdata;
    endtask

    // instruction-level interpreter: one loop iteration per instruction, cycles from the op class
    task automatic model_run();
        int p, op, rd, a, b, imm, r;
        logic [15:0] w;
        p = 0;
        mcyc = 1;
        mpc = -1;
        for (int g = 0; g < 2000; g++) begin
            w = prog[p];
            op = int'(w[15:12]);
            rd = int'(w[11:9]);
            a = int'(mr[w[8:6]]);
            b = int'(mr[w[5:3]]);
            imm = int'(w[7:0]);
            mcyc += (op == 9 || op == 10) ? 4 : 3;
            if (op == 15) begin
                mpc = p;
                return;
            end
            r = op == 0 ? a + b : op == 1 ? a - b : op == 2 ? a & b : op == 3 ? a | b : a ^ b;
            if (op <= 4) begin
                mr[rd] = 8'(r);
                mc = op == 0 ? r > 255 : op == 1 ? a < b : 1'b0;
                mz = (r & 255) == 0;
            end
            if (op == 8) mr[rd] = 8'(imm);
            if (op == 9) mr[rd] = mdm[imm];
            if (op == 10) mdm[imm] = mr[rd];
            p = (op == 12 || (op == 13 && mz) || (op == 14 && mc)) ? imm : (p + 1) % 256;
        end
    endtask

    task automatic check_all(input string t);
        for (int i = 0; i < 8; i++) begin
            dbg_raddr = 3'(i);
            dm_raddr = 8'(240 + i);
            #1;
            chk($sformatf("%s_r%0d", t, i), dbg_rdata, mr[i]);
            chk($sformatf("%s_dm%0d", t, i), dm_rdata, mdm[240 + i]);
        end
        chk({t, "_carry"}, carry, mc);
        chk({t, "_zero"}, zero, mz);
        chk({t, "_pc"}, pc, mpc);
        chk({t, "_halted"}, halted, 1);
    endtask

    initial begin
        int cyc, n, k;
        logic [7:0] v;
        reset = 1'b1;
        start = 1'b0;
        prog_we = 1'b0;
        w_start = 1'b0;
        w_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        dbg_raddr = '0;
        dm_raddr = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        for (int i = 0; i < 8; i++) begin
            rd_reg(i, v);
            chk($sformatf("rst_r%0d", i), v, 0);
        end

        // seed dmem 0xF0..0xF7 so later loads read known data
        do_reset();
        for (int i = 0; i < 8; i++) begin
            prog[2 * i] = ri(8, 0, i * 37 + 5);
            prog[2 * i + 1] = ri(10, 0, 240 + i);
        end
        prog[16] = ri(15, 0, 0);
        load(17);
        model_run();
        run(cyc);
        chk("init_cycles", cyc, mcyc);
        check_all("init");

        // LDI/LDI/ADD/ST/HALT
        do_reset();
        prog[0] = ri(8, 0, 7);
        prog[1] = ri(8, 1, 2);
        prog[2] = rr(0, 7, 0, 1);
        prog[3] = ri(10, 7, 8'hFF);
        prog[4] = ri(15, 0, 0);
        load(5);
        model_run();
        run(cyc);
        chk("add_cycles", cyc, 17);
        rd_dm(8'hFF, v);
        chk("add_dmFF", v, 9);
        chk("add_carry", carry, 0);
        chk("add_zero", zero, 0);
        check_all("add");

        // SUB with borrow, then SUB to zero loaded while halted
        do_reset();
        prog[0] = ri(8, 0, 2);
        prog[1] = ri(8, 1, 7);
        prog[2] = rr(1, 2, 0, 1);
        prog[3] = ri(15, 0, 0);
        load(4);
        model_run();
        run(cyc);
        rd_reg(2, v);
        chk("sub_r2", v, 8'hFB);
        chk("sub_carry", carry, 1);
        chk("sub_zero", zero, 0);
        prog[0] = rr(1, 3, 1, 1);
        prog[1] = ri(15, 0, 0);
        load(2);
        model_run();
        run(cyc);
        rd_reg(3, v);
        chk("sub0_r3", v, 0);
        chk("sub0_zero", zero, 1);
        chk("sub0_carry", carry, 0);
        check_all("sub0");

        // ADD overflow then taken JC over two LDIs
        do_reset();
        prog[0] = ri(8, 0, 8'hFF);
        prog[1] = ri(8, 1, 1);
        prog[2] = rr(0, 2, 0, 1);
        prog[3] = ri(14, 0, 6);
        prog[4] = ri(8, 4, 8'h11);
        prog[5] = ri(8, 4, 8'h22);
        prog[6] = ri(15, 0, 0);
        load(7);
        model_run();
        run(cyc);
        rd_reg(2, v);
        chk("jc_r2", v, 0);
        rd_reg(4, v);
        chk("jc_r4", v, 0);
        chk("jc_carry", carry, 1);
        chk("jc_zero", zero, 1);
        chk("jc_pc", pc, 6);
        chk("jc_cycles", cyc, 1 + 4 * 3 + 3);

        // reset during the MEM cycle of a store must drop the store
        do_reset();
        prog[0] = ri(8, 7, 8'hAA);
        prog[1] = ri(10, 7, 8'h10);
        prog[2] = ri(15, 0, 0);
        load(3);
        run(cyc);
        rd_dm(8'h10, v);
        chk("abort_pre_dm", v, 8'hAA);
        prog[0] = ri(8, 7, 8'h55);
        load(1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        #2;
        chk("abort_busy", busy, 0);
        chk("abort_halted", halted, 0);
        chk("abort_pc", pc, 0);
        step();
        reset = 1'b0;
        step();
        rd_dm(8'h10, v);
        chk("abort_dm", v, 8'hAA);
        for (int i = 0; i < 8; i++) begin
            rd_reg(i, v);
            chk($sformatf("abort_r%0d", i), v, 0);
        end

        // imem writes and start ignored while busy; honoured together in HALT
        do_reset();
        prog[0] = 16'h5000;
        prog[1] = 16'h6000;
        prog[2] = 16'hB000;
        prog[3] = ri(15, 0, 0);
        load(4);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        prog_we = 1'b1;
        prog_addr = 8'h00;
        prog_data = ri(8, 5, 8'h33);
        start = 1'b1;
        step();
        prog_we = 1'b0;
        start = 1'b0;
        cyc = 4;
        wait_halt(cyc);
        chk("busywe_cycles", cyc, 13);
        run(cyc);
        rd_reg(5, v);
        chk("busywe_r5", v, 0);
        prog_we = 1'b1;
        start = 1'b1;
        prog_addr = 8'h00;
        prog_data = ri(8, 5, 8'h33);
        step();
        prog_we = 1'b0;
        start = 1'b0;
        cyc = 1;
        wait_halt(cyc);
        chk("haltwe_cycles", cyc, 13);
        rd_reg(5, v);
        chk("haltwe_r5", v, 8'h33);

        // random straight-line programs with forward jumps
        for (int t = 0; t < 15; t++) begin
            do_reset();
            n = $urandom_range(6, 24);
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 9);
                prog[i] = k <= 3 || k == 9 ? rr($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7))
                        : k == 4 ? ri(8, $urandom_range(0, 7), $urandom_range(0, 255))
                        : k == 5 ? ri(9, $urandom_range(0, 7), 240 + $urandom_range(0, 7))
                        : k == 6 ? ri(10, $urandom_range(0, 7), 240 + $urandom_range(0, 7))
                        : k == 7 ? ri($urandom_range(0, 3) == 0 ? 11 : $urandom_range(5, 7), 0, $urandom_range(0, 255))
                        : ri($urandom_range(12, 14), 0, $urandom_range(i + 1, n));
            end
            prog[n] = ri(15, 0, 0);
            load(n + 1);
            model_run();
            run(cyc);
            chk($sformatf("rnd%0d_cycles", t), cyc, mcyc);
            check_all($sformatf("rnd%0d", t));
        end

        // PC_W=3 instance: eight NOPs and no HALT, pc wraps 7 -> 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w_we = 1'b1;
            prog_addr = 8'(i);
            prog_data = 16'h5000;
            step();
        end
        w_we = 1'b0;
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            chk($sformatf("wrap_pc%0d", c), w_pc, ((c - 1) / 3) % 8);
            chk($sformatf("wrap_busy%0d", c), w_busy, 1);
            step();
        end
        chk("wrap_halted", w_halted, 0);
        chk("wrap_carry", w_carry, 0);
        chk("wrap_zero", w_zero, 0);
        dbg_raddr = 3'd0;
        #1;
        chk("wrap_r0", w_dbg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_cpu_core.md
SEQ_CPU_CORE -- requirements
Module: seq_cpu_core

Interface
REQ-001 Parameter DW, default 8: datapath and register width; legal range 8..32.
REQ-002 Parameter PC_W, default 8: program counter width; legal range 3..8; instruction memory depth is 2**PC_W words of 16 bits.
REQ-003 Parameter DM_AW, default 8: data memory address width; depth is 2**DM_AW words of DW bits.
REQ-004 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: single-cycle pulse that begins execution at address 0.
REQ-007 Port prog_we, input, 1: instruction memory write enable.
REQ-008 Port prog_addr, input, PC_W: instruction memory write address.
REQ-009 Port prog_data, input, 16: instruction word to write.
REQ-010 Port dbg_raddr, input, 3: register-file debug read address.
REQ-011 Port dbg_rdata, output, DW: combinational read of register[dbg_raddr].
REQ-012 Port dm_raddr, input, DM_AW: data memory debug read address.
REQ-013 Port dm_rdata, output, DW: combinational read of dmem[dm_raddr].
REQ-014 Port pc, output, PC_W: current program counter.
REQ-015 Port busy, output, 1: high in FETCH, DECODE, EXEC and MEM.
REQ-016 Port halted, output, 1: high in HALT.
REQ-017 Port carry and zero, outputs, 1 each: ALU flags.

Function
REQ-018 Instruction fields: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm=[7:0]; imm is zero-extended to DW.
REQ-019 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 1000 LDI (rd<=imm), 1001 LD (rd<=dmem[imm]), 1010 ST (dmem[imm]<=rd), 1100 JMP, 1101 JZ, 1110 JC, 1111 HALT; every other opcode is a NOP.
REQ-020 FSM states: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
REQ-021 Transitions: IDLE->FETCH on start (pc<=0); FETCH->DECODE (ir<=imem[pc]); DECODE->EXEC; EXEC->MEM for LD/ST, EXEC->HALT for HALT, otherwise EXEC->FETCH; MEM->FETCH; HALT->FETCH on start (pc<=0).
REQ-022 Latency: ALU, LDI, jump and NOP instructions take 3 cycles; LD and ST take 4 cycles.
REQ-023 Register file: 8 x DW; written only in EXEC (ALU, LDI) or MEM (LD); every register including r0 is writable.
REQ-024 ADD: carry = bit DW of the (DW+1)-bit sum. SUB: carry = borrow, i.e. set when rs1 < rs2 unsigned. AND/OR/XOR: carry cleared.
REQ-025 zero is set when the DW-bit ALU result is 0; only ALU ops update carry and zero; LDI, LD and ST leave the flags unchanged.
REQ-026 pc increments by 1 in EXEC, modulo 2**PC_W (wrap from max to 0).
REQ-027 JMP loads pc<=imm[PC_W-1:0]; JZ and JC do so only when zero or carry respectively is set, otherwise pc increments.
REQ-028 ST with DM_AW < 8 uses imm[DM_AW-1:0]; LD addresses the same way.
REQ-029 prog_we is honoured only in IDLE or HALT and ignored otherwise.
REQ-030 start is ignored while busy.
REQ-031 If prog_we and start are both asserted in IDLE or HALT, the write completes and execution begins at address 0 with the written word visible at FETCH.

Reset
REQ-032 reset forces state=IDLE, pc=0, ir=0, carry=0, zero=0, busy=0, halted=0, and all registers to 0, asynchronously.
REQ-033 reset does not clear imem or dmem contents.
REQ-034 A reset asserted mid-instruction aborts it with no register or memory write.

Structure
REQ-035 A shared package holds the opcode constants, the state enumeration and the field bit positions.
REQ-036 One sub-module, cpu_alu, is combinational: op, a and b in; result, carry_out and flag_update out.

Verification
REQ-037 Program LDI r0,7; LDI r1,2; ADD r7,r0,r1; ST r7,0xFF; HALT, then start -> dm_rdata@0xFF=9, halted=1 after 17 cycles, carry=0, zero=0.
REQ-038 LDI r0,2; LDI r1,7; SUB r2,r0,r1 -> r2=0xFB, carry=1, zero=0; then SUB r3,r1,r1 -> r3=0, zero=1, carry=0.
REQ-039 LDI r0,0xFF; LDI r1,1; ADD r2,r0,r1; JC 0x06; at 0x06 HALT -> r2=0, carry=1, zero=1, halt at pc=6.
REQ-040 PC_W=3 with 8 NOPs and no HALT -> pc wraps 7->0 and busy stays 1.
REQ-041 Assert reset during MEM of ST r7,0x10 -> dmem[0x10] unchanged, state=IDLE, registers all 0.
REQ-042 prog_we to address 0 while busy -> imem[0] unchanged; the same write in HALT -> the new word executes after start.
